// File: rtl/uart_rx_fifo_if.sv
// Read-side bundle of uart_rx_fifo: FWFT FIFO head, valid/ready handshake and overrun status.
// break_det exists only when UART_RX_BREAK_DETECT_EN is defined.
interface uart_rx_fifo_if #(
    parameter int DATA_BIT_COUNT = 8
);
    logic                      rd_valid;
    logic                      rd_ready;
    logic [DATA_BIT_COUNT-1:0] data;
    logic                      parity_err;
    logic                      frame_err;
    logic                      overrun;
    logic                      overrun_clr;
`ifdef UART_RX_BREAK_DETECT_EN
    logic                      break_det;
`endif

    modport master (
        output rd_valid,
        output data,
        output parity_err,
        output frame_err,
        output overrun,
        input  rd_ready,
        input  overrun_clr
`ifdef UART_RX_BREAK_DETECT_EN
        , output break_det
`endif
    );

    modport slave (
        input  rd_valid,
        input  data,
        input  parity_err,
        input  frame_err,
        input  overrun,
        output rd_ready,
        output overrun_clr
`ifdef UART_RX_BREAK_DETECT_EN
        , input break_det
`endif
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver (5-9 data bits, none/odd/even parity, 1-2 stop bits) feeding a FWFT FIFO.
// Optional break detection is enabled by defining UART_RX_BREAK_DETECT_EN.
module uart_rx_fifo #(
    parameter int DATA_BIT_COUNT = 8,
    parameter int PARITY_MODE    = 0,
    parameter int STOP_BIT_COUNT = 1,
    parameter int CLK_PER_BIT    = 8,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          serial,
    uart_rx_fifo_if.master rx
);
    localparam int CNT_W    = $clog2(CLK_PER_BIT) + 1;
    localparam int HALF_CLK = (CLK_PER_BIT - 1) / 2;
    localparam int IDX_W    = $clog2(DATA_BIT_COUNT);
    localparam int PTR_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int ADDR_W   = PTR_W - 1;
    localparam int WORD_W   = DATA_BIT_COUNT + 2;

    localparam logic [CNT_W-1:0] C_HALF    = CNT_W'(HALF_CLK);
    localparam logic [CNT_W-1:0] C_BIT_END = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [IDX_W-1:0] C_DATA_LAST = IDX_W'(DATA_BIT_COUNT - 1);
    localparam logic [IDX_W-1:0] C_STOP_LAST = IDX_W'(STOP_BIT_COUNT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_t;

    logic                      r_sync1, r_serial_s;
    state_t                    r_state, w_state_nx;
    logic [CNT_W-1:0]          r_count, w_count_nx;
    logic [IDX_W-1:0]          r_idx, w_idx_nx;
    logic [DATA_BIT_COUNT-1:0] r_shift, w_shift_nx;
    logic                      r_par_err, w_par_err_nx;
    logic                      r_frm_err, w_frm_err_nx;
    logic                      w_bit_tick;
    logic                      w_frame_done;
    logic                      w_frame_ferr;
    logic                      w_parity;
    logic                      w_push;

    logic [WORD_W-1:0]         r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]          r_wr_ptr, r_rd_ptr;
    logic                      r_overrun;
    logic                      w_empty, w_full, w_pop, w_wr_en;

    // Two-flop synchroniser; the line idles high so the flops reset to 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1    <= 1'b1;
            r_serial_s <= 1'b1;
        end else begin
            r_sync1    <= serial;
            r_serial_s <= r_sync1;
        end
    end

    assign w_bit_tick = (r_count == C_BIT_END);
    assign w_parity   = ^r_shift ^ r_serial_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_idx     <= '0;
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_count   <= w_count_nx;
            r_idx     <= w_idx_nx;
            r_par_err <= w_par_err_nx;
            r_frm_err <= w_frm_err_nx;
        end
    end

    always_ff @(posedge clk) begin
        r_shift <= w_shift_nx;
    end

    always_comb begin
        w_state_nx   = r_state;
        w_count_nx   = r_count + 1'b1;
        w_idx_nx     = r_idx;
        w_shift_nx   = r_shift;
        w_par_err_nx = r_par_err;
        w_frm_err_nx = r_frm_err;
        w_frame_done = 1'b0;
        w_frame_ferr = r_frm_err;
        case (r_state)
            S_IDLE: begin
                w_count_nx   = '0;
                w_idx_nx     = '0;
                w_par_err_nx = 1'b0;
                w_frm_err_nx = 1'b0;
                if (!r_serial_s) w_state_nx = S_START;
            end
            S_START: begin
                if (r_count == C_HALF) begin
                    w_count_nx = '0;
                    w_state_nx = r_serial_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_tick) begin
                    w_count_nx = '0;
                    w_shift_nx = {r_serial_s, r_shift[DATA_BIT_COUNT-1:1]};
                    if (r_idx == C_DATA_LAST) begin
                        w_idx_nx   = '0;
                        w_state_nx = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                    end else begin
                        w_idx_nx = r_idx + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_tick) begin
                    w_count_nx   = '0;
                    w_par_err_nx = (PARITY_MODE == 1) ? !w_parity : w_parity;
                    w_state_nx   = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_tick) begin
                    w_count_nx = '0;
                    if (!r_serial_s) w_frm_err_nx = 1'b1;
                    if (r_idx == C_STOP_LAST) begin
                        w_frame_done = 1'b1;
                        w_frame_ferr = r_frm_err | !r_serial_s;
                        w_idx_nx     = '0;
                        w_state_nx   = r_serial_s ? S_IDLE : S_WAIT_HIGH;
                    end else begin
                        w_idx_nx = r_idx + 1'b1;
                    end
                end
            end
            S_WAIT_HIGH: begin
                w_count_nx = '0;
                if (r_serial_s) w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
                w_count_nx = '0;
            end
        endcase
    end

`ifdef UART_RX_BREAK_DETECT_EN
    logic r_par_bit, r_stop0_low, r_break_det;
    logic w_stop0_low, w_break;

    // First stop bit decides the break; with two stop bits it is remembered until the last one
    assign w_stop0_low = (r_idx == '0) ? !r_serial_s : r_stop0_low;
    assign w_break     = (r_shift == '0) && !r_par_bit && w_stop0_low;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par_bit   <= 1'b0;
            r_stop0_low <= 1'b0;
            r_break_det <= 1'b0;
        end else begin
            r_break_det <= w_frame_done && w_break;
            if (r_state == S_IDLE)
                r_par_bit <= 1'b0;
            else if (r_state == S_PARITY && w_bit_tick)
                r_par_bit <= r_serial_s;
            if (r_state == S_STOP && w_bit_tick && r_idx == '0)
                r_stop0_low <= !r_serial_s;
        end
    end

    assign w_push       = w_frame_done && !w_break;
    assign rx.break_det = r_break_det;
`else
    assign w_push = w_frame_done;
`endif

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W-1] != r_rd_ptr[PTR_W-1]) &&
                     (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
    assign w_pop   = !w_empty && rx.rd_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept
    assign w_wr_en = w_push && (!w_full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_mem[r_wr_ptr[ADDR_W-1:0]] <= {w_frame_ferr, r_par_err, r_shift};
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && w_full && !w_pop)
                r_overrun <= 1'b1;
            else if (rx.overrun_clr)
                r_overrun <= 1'b0;
        end
    end

    assign rx.rd_valid = !w_empty;
    assign rx.overrun  = r_overrun;
    assign {rx.frame_err, rx.parity_err, rx.data} = r_mem[r_rd_ptr[ADDR_W-1:0]];
endmodule
